ls161_timer_ctrl: RTL and testbench
===================================

LS161_TIMER_CTRL -- requirements
Module: ls161_timer_ctrl

Interface
REQ-001 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port CLR_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port START  input  1  request to load PRESET and begin counting; sampled on CLK.
REQ-004 SHALL have port STOP  input  1  abort request; sampled on CLK.
REQ-005 SHALL have port MODE  input  1  0 = one-shot, 1 = periodic; sampled on every CLK edge.
REQ-006 SHALL have port ENA  input  1  count enable (ENP/ENT equivalent) while running.
REQ-007 SHALL have port PRESET  input  8  start value; captured on the accepted-START edge only.
REQ-008 SHALL have port CNT  output  8  current count value, registered.
REQ-009 SHALL have port BUSY  output  1  high in LOAD and RUN states, registered.
REQ-010 SHALL have port DONE  output  1  one-cycle terminal pulse, registered.
REQ-011 SHALL have port RCO  output  1  combinational ripple carry: state==RUN and CNT==8'hFF and ENA.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, RUN; no other reachable states.
REQ-013 SHALL implement CNT as two cascaded 4-bit stages: low nibble increments when counting; high nibble increments only when low-nibble carry (CNT[3:0]==4'hF and counting) is true.
REQ-014 IDLE: if START=1 and STOP=0, SHALL capture PRESET into shadow register and go to LOAD; otherwise stay IDLE, CNT held.
REQ-015 LOAD: SHALL set CNT <= shadow and go to RUN on next edge, ignoring ENA.
REQ-016 RUN with ENA=0: SHALL hold CNT and state; DONE stays 0.
REQ-017 RUN with ENA=1 and CNT!=8'hFF: SHALL set CNT <= CNT+1.
REQ-018 RUN with ENA=1 and CNT==8'hFF: SHALL set DONE=1 for exactly the following cycle.
REQ-019 At that terminal edge with MODE=1: SHALL reload CNT <= shadow and stay in RUN.
REQ-020 At that terminal edge with MODE=0: SHALL go to IDLE with CNT held at 8'hFF.
REQ-021 STOP=1 in LOAD or RUN: SHALL go to IDLE on that edge, hold CNT, and suppress DONE, even if the terminal condition is true the same cycle.
REQ-022 START while BUSY=1: SHALL be ignored; shadow SHALL NOT change.
REQ-023 START and STOP both high in IDLE: SHALL stay IDLE.
REQ-024 Latency, ENA held 1, one-shot: DONE high on edge 258-PRESET after the accepted-START edge (edge 1 = LOAD, edge 2 = CNT=PRESET).
REQ-025 Periodic mode, ENA held 1: DONE pulses SHALL repeat every 256-PRESET cycles; PRESET=8'hFF gives DONE every cycle.
REQ-026 Changing PRESET while BUSY: SHALL have no effect until the next accepted START.
REQ-027 DONE SHALL be 0 in every cycle not following a terminal edge.

Reset
REQ-028 CLR_n=0: SHALL immediately, without waiting for CLK, force state=IDLE, CNT=8'h00, shadow=8'h00, BUSY=0, DONE=0; RCO therefore 0.
REQ-029 Reset mid-RUN: SHALL abort with no DONE pulse; operation resumes only after CLR_n=1 and a new START.
REQ-030 After CLR_n deasserts: the first edge SHALL be treated as a normal IDLE edge.

Verification
REQ-031 Bench SHALL cover: PRESET=8'hFC, MODE=0, ENA=1, START one cycle -> CNT FC,FD,FE,FF on edges 2-5; DONE=1 after edge 6 only; BUSY falls after edge 6; CNT stays FF.
REQ-032 Bench SHALL cover: PRESET=8'hFE, MODE=1, ENA=1 -> DONE every 2 cycles; CNT alternates FE,FF; RCO=1 whenever CNT==FF.
REQ-033 Bench SHALL cover: PRESET=8'h0E, ENA toggled 1,0,1 in RUN -> CNT 0E,0F,0F,10; high nibble increments only on low-nibble carry.
REQ-034 Bench SHALL cover: STOP=1 in the same cycle as CNT==FF, ENA=1 -> IDLE, CNT=FF, DONE stays 0.
REQ-035 Bench SHALL cover: CLR_n pulsed low between clock edges during RUN -> CNT=00 and BUSY=0 before the next edge; START re-accepted afterwards.
REQ-036 Bench SHALL cover: START asserted during RUN with a different PRESET -> ignored; the period is unchanged.

Source files
------------

// File: rtl/ls161_timer_ctrl_if.sv
// Control/status bundle for the LS161-style cascaded timer.
// The master drives the requests and PRESET. The slave returns the count and status.
interface ls161_timer_ctrl_if;
  localparam int unsigned CNT_W = 8;

  logic             START;
  logic             STOP;
  logic             MODE;
  logic             ENA;
  logic [CNT_W-1:0] PRESET;
  logic [CNT_W-1:0] CNT;
  logic             BUSY;
  logic             DONE;
  logic             RCO;

  modport master (
    output START, STOP, MODE, ENA, PRESET,
    input  CNT, BUSY, DONE, RCO
  );

  modport slave (
    input  START, STOP, MODE, ENA, PRESET,
    output CNT, BUSY, DONE, RCO
  );
endinterface

// File: rtl/ls161_timer_ctrl.sv
// Timer built from two cascaded 4-bit counter stages and sequenced by an IDLE/LOAD/RUN FSM.
// The timer supports one-shot and periodic terminal-count operation.
module ls161_timer_ctrl (
  input  logic                CLK,
  input  logic                CLR_n,
  ls161_timer_ctrl_if.slave   bus
);
  localparam int unsigned CNT_W = 8;
  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] shadow_q;
  logic             busy_q;
  logic             done_q;

  logic             lo_carry;
  logic [NIB_W-1:0] lo_nxt;
  logic [NIB_W-1:0] hi_nxt;
  logic             terminal;

  // The high stage advances only on the carry out of the low stage.
  assign lo_carry = (cnt_q[NIB_W-1:0] == {NIB_W{1'b1}});
  assign lo_nxt   = cnt_q[NIB_W-1:0] + NIB_W'(1);
  assign hi_nxt   = lo_carry ? (cnt_q[CNT_W-1:NIB_W] + NIB_W'(1)) : cnt_q[CNT_W-1:NIB_W];
  assign terminal = (state_q == ST_RUN) && bus.ENA && (cnt_q == {CNT_W{1'b1}});

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.START && !bus.STOP) begin
            shadow_q <= bus.PRESET;
            state_q  <= ST_LOAD;
            busy_q   <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (bus.STOP) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q   <= shadow_q;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          // STOP wins over a coincident terminal count and swallows its DONE.
          if (bus.STOP) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (terminal) begin
            done_q <= 1'b1;
            if (bus.MODE) begin
              cnt_q <= shadow_q;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else if (bus.ENA) begin
            cnt_q <= {hi_nxt, lo_nxt};
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.CNT  = cnt_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.RCO  = terminal;
endmodule

// File: tb/tb_ls161_timer_ctrl.sv
// Directed bench for ls161_timer_ctrl.
// Every expected value below is worked out by hand from the edge-by-edge timer behaviour.
module tb_ls161_timer_ctrl;
  logic CLK;
  logic CLR_n;
  int   checks;
  int   failures;

  ls161_timer_ctrl_if bus ();

  ls161_timer_ctrl dut (
    .CLK   (CLK),
    .CLR_n (CLR_n),
    .bus   (bus.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.START  = 1'b0;
    bus.STOP   = 1'b0;
    bus.MODE   = 1'b0;
    bus.ENA    = 1'b0;
    bus.PRESET = 8'h00;
  endtask

  task automatic test_reset();
    idle_inputs();
    CLR_n = 1'b0;
    #12;
    checks += 4;
    if (bus.CNT !== 8'h00) begin failures++; $display("FAIL reset_cnt got=%h exp=00", bus.CNT); end
    if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.BUSY); end
    if (bus.DONE !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.DONE); end
    if (bus.RCO !== 1'b0) begin failures++; $display("FAIL reset_rco got=%b exp=0", bus.RCO); end
    CLR_n = 1'b1;
    tick();
    checks += 2;
    if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL post_reset_busy got=%b exp=0", bus.BUSY); end
    if (bus.CNT !== 8'h00) begin failures++; $display("FAIL post_reset_cnt got=%h exp=00", bus.CNT); end
  endtask

  task automatic test_oneshot();
    logic [7:0] exp_cnt [7];
    logic       exp_busy[7];
    logic       exp_done[7];
    exp_cnt  = '{8'h00, 8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'hFF, 8'hFF};
    exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bus.PRESET = 8'hFC; bus.MODE = 1'b0; bus.ENA = 1'b1; bus.START = 1'b1;
    for (int e = 0; e < 7; e++) begin
      tick();
      bus.START = 1'b0;
      checks += 3;
      if (bus.CNT !== exp_cnt[e]) begin failures++; $display("FAIL oneshot_cnt edge=%0d got=%h exp=%h", e + 1, bus.CNT, exp_cnt[e]); end
      if (bus.BUSY !== exp_busy[e]) begin failures++; $display("FAIL oneshot_busy edge=%0d got=%b exp=%b", e + 1, bus.BUSY, exp_busy[e]); end
      if (bus.DONE !== exp_done[e]) begin failures++; $display("FAIL oneshot_done edge=%0d got=%b exp=%b", e + 1, bus.DONE, exp_done[e]); end
      if (e == 4) begin
        checks++;
        if (bus.RCO !== 1'b1) begin failures++; $display("FAIL oneshot_rco got=%b exp=1", bus.RCO); end
      end
    end
  endtask

  task automatic test_periodic();
    logic [7:0] exp_cnt [6];
    logic       exp_done[6];
    exp_cnt  = '{8'hFF, 8'hFE, 8'hFF, 8'hFE, 8'hFF, 8'hFE};
    exp_done = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    bus.PRESET = 8'hFE; bus.MODE = 1'b1; bus.ENA = 1'b1; bus.START = 1'b1;
    for (int e = 0; e < 6; e++) begin
      tick();
      bus.START = 1'b0;
      checks += 3;
      if (bus.CNT !== exp_cnt[e]) begin failures++; $display("FAIL periodic_cnt edge=%0d got=%h exp=%h", e + 1, bus.CNT, exp_cnt[e]); end
      if (bus.DONE !== exp_done[e]) begin failures++; $display("FAIL periodic_done edge=%0d got=%b exp=%b", e + 1, bus.DONE, exp_done[e]); end
      if (bus.RCO !== (e >= 1 && exp_cnt[e] == 8'hFF)) begin
        failures++; $display("FAIL periodic_rco edge=%0d got=%b cnt=%h", e + 1, bus.RCO, bus.CNT);
      end
    end
    bus.STOP = 1'b1;
    tick();
    bus.STOP = 1'b0;
    checks += 3;
    if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL periodic_stop_busy got=%b exp=0", bus.BUSY); end
    if (bus.CNT !== 8'hFE) begin failures++; $display("FAIL periodic_stop_cnt got=%h exp=FE", bus.CNT); end
    if (bus.DONE !== 1'b0) begin failures++; $display("FAIL periodic_stop_done got=%b exp=0", bus.DONE); end
  endtask

  task automatic test_ena_carry();
    logic [7:0] exp_cnt[5];
    logic       ena_seq[5];
    exp_cnt = '{8'h0E, 8'h0F, 8'h0F, 8'h10, 8'h10};
    ena_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    bus.PRESET = 8'h0E; bus.MODE = 1'b0; bus.ENA = 1'b0; bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    for (int e = 0; e < 4; e++) begin
      tick();
      bus.ENA = ena_seq[e];
      checks += 2;
      if (bus.CNT !== exp_cnt[e]) begin failures++; $display("FAIL carry_cnt step=%0d got=%h exp=%h", e, bus.CNT, exp_cnt[e]); end
      if (bus.DONE !== 1'b0) begin failures++; $display("FAIL carry_done step=%0d got=%b exp=0", e, bus.DONE); end
    end
    bus.STOP = 1'b1;
    tick();
    bus.STOP = 1'b0;
    checks++;
    if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL carry_stop_busy got=%b exp=0", bus.BUSY); end
  endtask

  task automatic test_stop_terminal();
    bus.PRESET = 8'hFE; bus.MODE = 1'b0; bus.ENA = 1'b1; bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    tick();
    tick();
    bus.STOP = 1'b1;
    #1;
    checks += 2;
    if (bus.CNT !== 8'hFF) begin failures++; $display("FAIL stopterm_pre_cnt got=%h exp=FF", bus.CNT); end
    if (bus.RCO !== 1'b1) begin failures++; $display("FAIL stopterm_pre_rco got=%b exp=1", bus.RCO); end
    tick();
    bus.STOP = 1'b0;
    checks += 3;
    if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL stopterm_busy got=%b exp=0", bus.BUSY); end
    if (bus.CNT !== 8'hFF) begin failures++; $display("FAIL stopterm_cnt got=%h exp=FF", bus.CNT); end
    if (bus.DONE !== 1'b0) begin failures++; $display("FAIL stopterm_done got=%b exp=0", bus.DONE); end
    tick();
    checks++;
    if (bus.DONE !== 1'b0) begin failures++; $display("FAIL stopterm_done_late got=%b exp=0", bus.DONE); end
  endtask

  task automatic test_async_reset();
    bus.PRESET = 8'h10; bus.MODE = 1'b1; bus.ENA = 1'b1; bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.CNT !== 8'h11) begin failures++; $display("FAIL areset_run_cnt got=%h exp=11", bus.CNT); end
    #2;
    CLR_n = 1'b0;
    #1;
    checks += 3;
    if (bus.CNT !== 8'h00) begin failures++; $display("FAIL areset_cnt got=%h exp=00", bus.CNT); end
    if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL areset_busy got=%b exp=0", bus.BUSY); end
    if (bus.RCO !== 1'b0) begin failures++; $display("FAIL areset_rco got=%b exp=0", bus.RCO); end
    #2;
    CLR_n = 1'b1;
    tick();
    checks += 2;
    if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL areset_idle_busy got=%b exp=0", bus.BUSY); end
    if (bus.DONE !== 1'b0) begin failures++; $display("FAIL areset_idle_done got=%b exp=0", bus.DONE); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_cnt [7];
    logic       exp_done[7];
    exp_cnt  = '{8'hFD, 8'hFE, 8'hFF, 8'hFD, 8'hFE, 8'hFF, 8'hFD};
    exp_done = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    bus.PRESET = 8'hFD; bus.MODE = 1'b1; bus.ENA = 1'b1; bus.START = 1'b1;
    tick();
    checks++;
    if (bus.BUSY !== 1'b1) begin failures++; $display("FAIL b2b_accept_busy got=%b exp=1", bus.BUSY); end
    bus.PRESET = 8'hF0;
    for (int e = 0; e < 7; e++) begin
      tick();
      checks += 2;
      if (bus.CNT !== exp_cnt[e]) begin failures++; $display("FAIL b2b_cnt edge=%0d got=%h exp=%h", e + 2, bus.CNT, exp_cnt[e]); end
      if (bus.DONE !== exp_done[e]) begin failures++; $display("FAIL b2b_done edge=%0d got=%b exp=%b", e + 2, bus.DONE, exp_done[e]); end
    end
    bus.STOP = 1'b1;
    tick();
    tick();
    checks += 2;
    if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL both_high_busy got=%b exp=0", bus.BUSY); end
    if (bus.CNT !== 8'hFD) begin failures++; $display("FAIL both_high_cnt got=%h exp=FD", bus.CNT); end
    idle_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_ena_carry();
    test_stop_terminal();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
